// File: rtl/uart_tx_pkg.sv
// Constants and types shared by the UART transmit and receive paths.
// The default baud constant sits here so the receiver runs at the same bit rate.
package uart_tx_pkg;

  localparam int UART_BPS_CNT = 868;  // 100 MHz / 115200

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  // Byte idx of a word, where byte 0 is bits [7:0].
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] sh;
    sh = word >> (8 * idx);
    return sh[7:0];
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..BPS_CNT-1 and pulses tick on the terminal count.
// The clr input holds the counter at 0.
module uart_baud_tick #(
  parameter int BPS_CNT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(BPS_CNT);
  localparam logic [W-1:0] TERM = W'(BPS_CNT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: sends 1-4 bytes of a captured 32-bit word as 8N1 frames.
// Bytes go out least-significant first, and frames for the same word are sent back-to-back.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BPS_CNT = UART_BPS_CNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [1:0]  byte_cnt,
  input  logic        valid_in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  uart_tx_state_t state_q, state_d;
  logic [31:0]    word_q, word_d;
  logic [1:0]     nbytes_q, nbytes_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           tx_q, tx_d;
  logic           done_q, done_d;
  logic [7:0]     cur_byte;
  logic           tick;

  // The counter is held at 0 while idle, so each word starts on a fresh bit period.
  uart_baud_tick #(.BPS_CNT(BPS_CNT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  assign ready = (state_q == IDLE);
  assign busy  = !ready;
  assign done  = done_q;
  assign tx    = tx_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    nbytes_d   = nbytes_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: if (valid_in) begin
        word_d     = data_in;
        nbytes_d   = byte_cnt;
        byte_idx_d = '0;
        bit_idx_d  = '0;
        state_d    = START;
      end
      START: if (tick) begin
        bit_idx_d = '0;
        state_d   = DATA;
      end
      DATA: if (tick) begin
        if (bit_idx_q == 3'd7) state_d = STOP;
        else                   bit_idx_d = bit_idx_q + 3'd1;
      end
      STOP: if (tick) begin
        if (byte_idx_q < nbytes_q) begin
          byte_idx_d = byte_idx_q + 2'd1;
          state_d    = START;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is driven from the level of the state being entered.
    cur_byte = sel_byte(word_d, byte_idx_d);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      nbytes_q   <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      nbytes_q   <= nbytes_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

endmodule
